// File: rtl/fas_arb2.sv
// fas_arb2: two-requester round-robin arbiter and 2-stage pipeline around the shared 8-bit add/sub unit
module fas_addsub8 (
  input  logic [7:0] x,
  input  logic [7:0] yo,
  input  logic       cin,
  output logic [7:0] res,
  output logic       co
);
  logic [8:0] s;
  assign s   = {1'b0, x} + {1'b0, yo ^ {8{cin}}} + {8'd0, cin};
  assign res = s[7:0];
  assign co  = s[8] ^ cin;
endmodule

module fas_arb2 #(
  parameter int RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_x0,
  input  logic [7:0] req_y0,
  input  logic       req_sub0,
  input  logic [7:0] req_x1,
  input  logic [7:0] req_y1,
  input  logic       req_sub1,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [7:0] resp_res,
  output logic       resp_co,
  output logic       resp_ovf,
  output logic       resp_zero
);
  logic       prio;
  logic [1:0] grant;
  logic       hs;
  logic       gid;
  logic       s1_valid;
  logic       s1_id;
  logic [7:0] s1_x;
  logic [7:0] s1_y;
  logic       s1_sub;
  logic [7:0] sum;
  logic       co;
  logic       ovf;
  // A lone requester always wins; on contention the prio holder wins
  always_comb begin
    grant[0]  = req_valid[0] & (~req_valid[1] | ~prio);
    grant[1]  = req_valid[1] & (~req_valid[0] | prio);
    req_ready = rst ? 2'b00 : grant;
    hs        = |req_ready;
    gid       = req_ready[1];
  end
  // Priority passes to the loser of each handshake
  always_ff @(posedge clk)
    if (rst) prio <= 1'(RESET_PRIO);
    else if (hs) prio <= ~gid;
  // Issue register captures the granted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_x     <= 8'd0;
      s1_y     <= 8'd0;
      s1_sub   <= 1'b0;
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_id  <= gid;
        s1_x   <= gid ? req_x1 : req_x0;
        s1_y   <= gid ? req_y1 : req_y0;
        s1_sub <= gid ? req_sub1 : req_sub0;
      end
    end
  end
  fas_addsub8 u_alu (
    .x   (s1_x),
    .yo  (s1_y),
    .cin (s1_sub),
    .res (sum),
    .co  (co)
  );
  // Signed overflow: operand signs that should agree (add) or differ (sub), result sign flipped
  always_comb
    ovf = ((s1_x[7] ^ s1_y[7]) == s1_sub) & (sum[7] != s1_x[7]);
  // Response register; data fields hold between results
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_res   <= 8'd0;
      resp_co    <= 1'b0;
      resp_ovf   <= 1'b0;
      resp_zero  <= 1'b0;
    end else begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_id   <= s1_id;
        resp_res  <= sum;
        resp_co   <= co;
        resp_ovf  <= ovf;
        resp_zero <= sum == 8'd0;
      end
    end
  end
endmodule
